// File: rtl/i2c_target_fifo.sv
// rtl/i2c_target_fifo.sv - I2C target with programmable address, RX FIFO and TX FIFO
//
// i2c_target_fifo: oversampled I2C target. Decodes START/repeated START/STOP,
// matches own_addr_i, pushes written words into the RX FIFO and serves read
// words from the TX FIFO (FILL_WORD when empty).
//   clk, rst            system clock (>=8x SCL), synchronous active-high reset
//   scl_i, sda_i        bus inputs; sda_oe_o = 1 pulls SDA low
//   own_addr_i          target address, sampled at each address phase
//   rx_data_o/valid/ready   RX FIFO head and pop handshake
//   tx_data_i/valid/ready   TX FIFO push handshake
//   busy_o, op_o        transfer in progress, R/W bit of addressed transfer
//   start_o, stop_o, rx_overflow_o, tx_underflow_o   one-cycle event pulses
// i2c_target_fifo_buf: circular FIFO with wrapping pointers and a count.

module i2c_target_fifo_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is accepted only when a pop frees a slot the same cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module i2c_target_fifo #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int RX_DEPTH    = 4,
    parameter int TX_DEPTH    = 4,
    parameter int SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe_o,
    input  logic [ADDR_WIDTH-1:0] own_addr_i,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic                  busy_o,
    output logic                  op_o,
    output logic                  start_o,
    output logic                  stop_o,
    output logic                  rx_overflow_o,
    output logic                  tx_underflow_o
);
    localparam int SH_W  = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
    localparam int CNT_W = $clog2(SH_W + 1);
    localparam logic [CNT_W-1:0] ADDR_BITS = CNT_W'(ADDR_WIDTH + 1);
    localparam logic [CNT_W-1:0] DATA_BITS = CNT_W'(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP
    } state_t;

    // Input synchronisers plus one delay flop; preset high so reset looks like an idle bus.
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_s, sda_s, scl_d, sda_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  =  scl_s & ~scl_d;
    assign scl_fall  = ~scl_s &  scl_d;
    assign start_det =  scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  =  scl_s & scl_d & ~sda_d & sda_s;

    // FIFOs
    logic                  rx_push, rx_pop, rx_full, rx_empty;
    logic                  tx_pop, tx_full, tx_empty;
    logic [DATA_WIDTH-1:0] tx_head;
    logic [SH_W-1:0]       shreg, shreg_n;

    assign rx_pop     = ~rx_empty & rx_ready_i;
    assign rx_valid_o = ~rx_empty;
    assign tx_ready_o = ~tx_full;

    i2c_target_fifo_buf #(.WIDTH(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (shreg[DATA_WIDTH-1:0]),
        .pop       (rx_pop),
        .head      (rx_data_o),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    i2c_target_fifo_buf #(.WIDTH(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_valid_i),
        .push_data (tx_data_i),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    // Protocol FSM and datapath registers
    state_t                state, state_n;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_n;
    logic [DATA_WIDTH-1:0] tx_sh, tx_sh_n, tx_word;
    logic                  sda_oe, sda_oe_n, busy, busy_n, op, op_n, mack, mack_n;
    logic                  start_p, start_n, stop_p, stop_n, ovf_p, ovf_n, unf_p, unf_n;
    logic                  load_word;

    assign tx_word = tx_empty ? FILL_WORD : tx_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            tx_sh   <= '0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            op      <= 1'b0;
            mack    <= 1'b1;
            start_p <= 1'b0;
            stop_p  <= 1'b0;
            ovf_p   <= 1'b0;
            unf_p   <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            tx_sh   <= tx_sh_n;
            sda_oe  <= sda_oe_n;
            busy    <= busy_n;
            op      <= op_n;
            mack    <= mack_n;
            start_p <= start_n;
            stop_p  <= stop_n;
            ovf_p   <= ovf_n;
            unf_p   <= unf_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        tx_sh_n   = tx_sh;
        sda_oe_n  = sda_oe;
        busy_n    = busy;
        op_n      = op;
        mack_n    = mack;
        start_n   = 1'b0;
        stop_n    = 1'b0;
        ovf_n     = 1'b0;
        unf_n     = 1'b0;
        rx_push   = 1'b0;
        tx_pop    = 1'b0;
        load_word = 1'b0;

        if (stop_det) begin
            stop_n   = 1'b1;
            busy_n   = 1'b0;
            sda_oe_n = 1'b0;
            state_n  = IDLE;
        end else if (start_det) begin
            start_n   = 1'b1;
            busy_n    = 1'b1;
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            shreg_n   = '0;
            state_n   = ADDR;
        end else begin
            case (state)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shreg_n   = {shreg[SH_W-2:0], sda_s};
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                    end else if (scl_fall && bit_cnt == ADDR_BITS) begin
                        if (shreg[ADDR_WIDTH:1] == own_addr_i) begin
                            op_n     = shreg[0];
                            sda_oe_n = 1'b1;
                            state_n  = ADDR_ACK;
                        end else begin
                            state_n = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_n = 1'b0;
                        if (op) begin
                            load_word = 1'b1;
                        end else begin
                            bit_cnt_n = '0;
                            state_n   = RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (scl_rise) begin
                        shreg_n   = {shreg[SH_W-2:0], sda_s};
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                    end else if (scl_fall && bit_cnt == DATA_BITS) begin
                        // A pop in this same cycle frees a slot, so the word still fits.
                        if (!rx_full || rx_pop) begin
                            rx_push  = 1'b1;
                            sda_oe_n = 1'b1;
                            state_n  = RX_ACK;
                        end else begin
                            ovf_n   = 1'b1;
                            state_n = WAIT_STOP;
                        end
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = '0;
                        state_n   = RX_DATA;
                    end
                end
                TX_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                    end else if (scl_fall && bit_cnt != '0) begin
                        if (bit_cnt == DATA_BITS) begin
                            sda_oe_n = 1'b0;
                            state_n  = TX_ACK;
                        end else begin
                            tx_sh_n  = {tx_sh[DATA_WIDTH-2:0], 1'b0};
                            sda_oe_n = ~tx_sh[DATA_WIDTH-2];
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        mack_n = sda_s;
                    end else if (scl_fall) begin
                        if (!mack) load_word = 1'b1;
                        else       state_n   = WAIT_STOP;
                    end
                end
                WAIT_STOP: ;
                default: state_n = IDLE;
            endcase
        end

        // Shared word load for the first read byte and every master-ACKed byte.
        if (load_word) begin
            tx_pop    = ~tx_empty;
            unf_n     = tx_empty;
            tx_sh_n   = tx_word;
            sda_oe_n  = ~tx_word[DATA_WIDTH-1];
            bit_cnt_n = '0;
            state_n   = TX_DATA;
        end
    end

    assign sda_oe_o       = sda_oe;
    assign busy_o         = busy;
    assign op_o           = op;
    assign start_o        = start_p;
    assign stop_o         = stop_p;
    assign rx_overflow_o  = ovf_p;
    assign tx_underflow_o = unf_p;
endmodule

// File: tb/tb_i2c_target_fifo.sv
// tb/tb_i2c_target_fifo.sv - self-checking bench for i2c_target_fifo
module tb_i2c_target_fifo;
    localparam int Q        = 5;
    localparam int RX_DEPTH = 4;
    localparam int TX_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst, m_scl, m_sda, sda_bus;
    logic [6:0] own;
    logic [7:0] rx_data, tx_data;
    logic       rx_valid, rx_ready, tx_valid, tx_ready;
    logic       sda_oe, busy, op, start_p, stop_p, ovf_p, unf_p;

    int n_pass = 0, n_total = 0;
    int n_start = 0, n_stop = 0, n_ovf = 0, n_unf = 0, n_oe = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];

    assign sda_bus = m_sda & ~sda_oe;

    i2c_target_fifo dut (
        .clk(clk), .rst(rst), .scl_i(m_scl), .sda_i(sda_bus), .sda_oe_o(sda_oe),
        .own_addr_i(own), .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .busy_o(busy), .op_o(op), .start_o(start_p), .stop_o(stop_p),
        .rx_overflow_o(ovf_p), .tx_underflow_o(unf_p)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start_p) n_start++;
        if (stop_p)  n_stop++;
        if (ovf_p)   n_ovf++;
        if (unf_p)   n_unf++;
        if (sda_oe)  n_oe++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start;
        tick(Q); m_sda = 1'b1;
        tick(Q); m_scl = 1'b1;
        tick(Q); m_sda = 1'b0;
        tick(Q); m_scl = 1'b0;
    endtask

    task automatic i2c_stop;
        tick(Q); m_sda = 1'b0;
        tick(Q); m_scl = 1'b1;
        tick(Q); m_sda = 1'b1;
        tick(Q);
    endtask

    task automatic bit_cycle(input logic b, output logic seen);
        tick(Q); m_sda = b;
        tick(Q); m_scl = 1'b1;
        tick(Q); seen = sda_bus;
        tick(Q); m_scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
        bit_cycle(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, s);
            d[i] = s;
        end
        bit_cycle(mack, s);
    endtask

    task automatic push_tx(input logic [7:0] v);
        tx_data = v; tx_valid = 1'b1;
        if (tx_q.size() < TX_DEPTH) tx_q.push_back(v);
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1; tick(2); rst = 1'b0; tick(1);
        rx_q.delete(); tx_q.delete();
    endtask

    task automatic test_reset;
        do_reset;
        n_total++; if (sda_oe !== 1'b0)   $display("FAIL rst_sda_oe got=%0b exp=0", sda_oe);   else n_pass++;
        n_total++; if (busy !== 1'b0)     $display("FAIL rst_busy got=%0b exp=0", busy);       else n_pass++;
        n_total++; if (op !== 1'b0)       $display("FAIL rst_op got=%0b exp=0", op);           else n_pass++;
        n_total++; if (rx_valid !== 1'b0) $display("FAIL rst_rx_valid got=%0b exp=0", rx_valid); else n_pass++;
        n_total++; if (tx_ready !== 1'b1) $display("FAIL rst_tx_ready got=%0b exp=1", tx_ready); else n_pass++;
        n_total++; if ({start_p, stop_p, ovf_p, unf_p} !== 4'b0)
            $display("FAIL rst_pulses got=%b exp=0000", {start_p, stop_p, ovf_p, unf_p}); else n_pass++;
    endtask

    task automatic test_write;
        logic ack, exp_ack;
        logic [7:0] bytes[3], e;
        int s0, p0;
        bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'($urandom);
        own = 7'h27; s0 = n_start; p0 = n_stop;
        i2c_start;
        write_byte(8'h4E, ack);
        n_total++; if (ack !== 1'b0) $display("FAIL wr_addr_ack got=%0b exp=0", ack); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            write_byte(bytes[i], ack);
            exp_ack = (rx_q.size() < RX_DEPTH) ? 1'b0 : 1'b1;
            if (!exp_ack) rx_q.push_back(bytes[i]);
            n_total++; if (ack !== exp_ack) $display("FAIL wr_data_ack[%0d] got=%0b exp=%0b", i, ack, exp_ack); else n_pass++;
        end
        n_total++; if (busy !== 1'b1 || op !== 1'b0) $display("FAIL wr_busy_op got=%0b%0b exp=10", busy, op); else n_pass++;
        i2c_stop;
        n_total++; if (n_start - s0 != 1) $display("FAIL wr_start_count got=%0d exp=1", n_start - s0); else n_pass++;
        n_total++; if (n_stop - p0 != 1)  $display("FAIL wr_stop_count got=%0d exp=1", n_stop - p0);  else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL wr_busy_after_stop got=%0b exp=0", busy); else n_pass++;
        while (rx_q.size() > 0) begin
            e = rx_q.pop_front();
            n_total++; if (rx_valid !== 1'b1 || rx_data !== e)
                $display("FAIL wr_rx_pop got=%0b/%h exp=1/%h", rx_valid, rx_data, e); else n_pass++;
            rx_ready = 1'b1; tick(1); rx_ready = 1'b0;
        end
        n_total++; if (rx_valid !== 1'b0) $display("FAIL wr_rx_empty got=%0b exp=0", rx_valid); else n_pass++;
    endtask

    task automatic test_read;
        logic ack;
        logic [7:0] d, e;
        logic mack[3];
        int u0, u_exp, oe0;
        mack[0] = 1'b0; mack[1] = 1'b0; mack[2] = 1'b1;
        push_tx(8'h11); push_tx(8'h22);
        u0 = n_unf; u_exp = 0;
        i2c_start;
        write_byte(8'h4F, ack);
        n_total++; if (ack !== 1'b0) $display("FAIL rd_addr_ack got=%0b exp=0", ack); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            read_byte(mack[i], d);
            if (tx_q.size() > 0) e = tx_q.pop_front();
            else begin e = 8'hFF; u_exp++; end
            n_total++; if (d !== e) $display("FAIL rd_data[%0d] got=%h exp=%h", i, d, e); else n_pass++;
        end
        n_total++; if (op !== 1'b1) $display("FAIL rd_op got=%0b exp=1", op); else n_pass++;
        n_total++; if (n_unf - u0 != u_exp) $display("FAIL rd_underflow got=%0d exp=%0d", n_unf - u0, u_exp); else n_pass++;
        oe0 = n_oe;
        read_byte(1'b1, d);
        i2c_stop;
        n_total++; if (d !== 8'hFF) $display("FAIL rd_after_nack_bus got=%h exp=ff", d); else n_pass++;
        n_total++; if (n_oe != oe0) $display("FAIL rd_after_nack_oe got=%0d exp=%0d", n_oe, oe0); else n_pass++;
        n_total++; if (n_unf - u0 != u_exp) $display("FAIL rd_after_nack_unf got=%0d exp=%0d", n_unf - u0, u_exp); else n_pass++;
    endtask

    task automatic test_addr_nack;
        logic ack;
        logic [6:0] a;
        own = 7'h27;
        for (int k = 0; k < 2; k++) begin
            a = (k == 0) ? 7'h28 : 7'($urandom_range(0, 127));
            if (a == own) a = 7'h55;
            i2c_start;
            write_byte({a, 1'b0}, ack);
            n_total++; if (ack !== 1'b1) $display("FAIL na_addr_ack[%0d] got=%0b exp=1", k, ack); else n_pass++;
            write_byte(8'($urandom), ack);
            n_total++; if (ack !== 1'b1) $display("FAIL na_data_ack[%0d] got=%0b exp=1", k, ack); else n_pass++;
            n_total++; if (busy !== 1'b1) $display("FAIL na_busy[%0d] got=%0b exp=1", k, busy); else n_pass++;
            i2c_stop;
            n_total++; if (busy !== 1'b0 || rx_valid !== 1'b0)
                $display("FAIL na_after_stop[%0d] got=%0b%0b exp=00", k, busy, rx_valid); else n_pass++;
        end
    endtask

    task automatic test_overflow;
        logic ack, exp_ack;
        logic [7:0] b, e;
        int o0, o_exp;
        rx_ready = 1'b0; o0 = n_ovf; o_exp = 0;
        i2c_start;
        write_byte(8'h4E, ack);
        n_total++; if (ack !== 1'b0) $display("FAIL ov_addr_ack got=%0b exp=0", ack); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            write_byte(b, ack);
            exp_ack = (rx_q.size() < RX_DEPTH) ? 1'b0 : 1'b1;
            if (!exp_ack) rx_q.push_back(b);
            else if (o_exp == 0) o_exp = 1;
            n_total++; if (ack !== exp_ack) $display("FAIL ov_ack[%0d] got=%0b exp=%0b", i, ack, exp_ack); else n_pass++;
        end
        i2c_stop;
        n_total++; if (n_ovf - o0 != o_exp) $display("FAIL ov_pulse got=%0d exp=%0d", n_ovf - o0, o_exp); else n_pass++;
        while (rx_q.size() > 0) begin
            e = rx_q.pop_front();
            n_total++; if (rx_valid !== 1'b1 || rx_data !== e)
                $display("FAIL ov_rx_pop got=%0b/%h exp=1/%h", rx_valid, rx_data, e); else n_pass++;
            rx_ready = 1'b1; tick(1); rx_ready = 1'b0;
        end
        n_total++; if (rx_valid !== 1'b0) $display("FAIL ov_rx_empty got=%0b exp=0", rx_valid); else n_pass++;
    endtask

    task automatic test_repeated_start;
        logic ack;
        logic [7:0] d, e;
        int s0;
        push_tx(8'($urandom));
        s0 = n_start;
        i2c_start;
        write_byte(8'h4E, ack);
        n_total++; if (op !== 1'b0) $display("FAIL rs_op_write got=%0b exp=0", op); else n_pass++;
        write_byte(8'hA5, ack);
        rx_q.push_back(8'hA5);
        n_total++; if (ack !== 1'b0) $display("FAIL rs_data_ack got=%0b exp=0", ack); else n_pass++;
        i2c_start;
        write_byte(8'h4F, ack);
        n_total++; if (ack !== 1'b0 || op !== 1'b1) $display("FAIL rs_read_addr got=%0b/%0b exp=0/1", ack, op); else n_pass++;
        read_byte(1'b1, d);
        e = tx_q.pop_front();
        n_total++; if (d !== e) $display("FAIL rs_read_data got=%h exp=%h", d, e); else n_pass++;
        i2c_stop;
        n_total++; if (n_start - s0 != 2) $display("FAIL rs_start_count got=%0d exp=2", n_start - s0); else n_pass++;
        e = rx_q.pop_front();
        n_total++; if (rx_valid !== 1'b1 || rx_data !== e)
            $display("FAIL rs_rx_data got=%0b/%h exp=1/%h", rx_valid, rx_data, e); else n_pass++;
        rx_ready = 1'b1; tick(1); rx_ready = 1'b0;
    endtask

    task automatic test_reset_mid_read;
        logic ack, s;
        logic [7:0] d, w;
        int u0, s0, cyc;
        i2c_start; write_byte(8'h4E, ack); write_byte(8'($urandom), ack); i2c_stop;
        push_tx(8'($urandom) & 8'h7F);
        push_tx(8'($urandom));
        i2c_start;
        write_byte(8'h4F, ack);
        cyc = 0;
        while (sda_oe !== 1'b1 && cyc < 20) begin tick(1); cyc++; end
        n_total++; if (sda_oe !== 1'b1) $display("FAIL mr_drive_zero got=%0b exp=1", sda_oe); else n_pass++;
        rst = 1'b1; tick(1); rst = 1'b0;
        rx_q.delete(); tx_q.delete();
        n_total++; if (sda_oe !== 1'b0) $display("FAIL mr_release got=%0b exp=0", sda_oe); else n_pass++;
        n_total++; if (rx_valid !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL mr_state got=%0b%0b%0b exp=010", rx_valid, tx_ready, busy); else n_pass++;
        s0 = n_start;
        for (int i = 7; i >= 0; i--) begin bit_cycle(1'b1, s); d[i] = s; end
        bit_cycle(1'b1, s);
        i2c_stop;
        n_total++; if (d !== 8'hFF || n_start != s0) $display("FAIL mr_ignored got=%h/%0d exp=ff/%0d", d, n_start, s0); else n_pass++;
        u0 = n_unf;
        i2c_start;
        write_byte(8'h4F, ack);
        read_byte(1'b1, d);
        i2c_stop;
        n_total++; if (ack !== 1'b0 || d !== 8'hFF) $display("FAIL mr_new_read got=%0b/%h exp=0/ff", ack, d); else n_pass++;
        n_total++; if (n_unf - u0 != 1) $display("FAIL mr_underflow got=%0d exp=1", n_unf - u0); else n_pass++;
        w = 8'($urandom);
        i2c_start; write_byte(8'h4E, ack); write_byte(w, s); i2c_stop;
        n_total++; if (ack !== 1'b0 || s !== 1'b0 || rx_valid !== 1'b1 || rx_data !== w)
            $display("FAIL mr_new_write got=%0b%0b%0b/%h exp=001/%h", ack, s, rx_valid, rx_data, w); else n_pass++;
        rx_ready = 1'b1; tick(1); rx_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; own = 7'h27;
        rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        tick(3);
        test_reset;
        test_write;
        test_read;
        test_addr_nack;
        test_overflow;
        test_repeated_start;
        test_reset_mid_read;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
